// File: rtl/freqmeas_pkg.sv
// Shared types, widths and helpers for the REF-rate CKV frequency meter.
package freqmeas_pkg;

  localparam int DEF_CNT_W = 7;
  localparam int DEF_TDC_W = 6;
  localparam int DEF_FR_W  = 16;
  localparam int PH_W      = DEF_CNT_W + DEF_FR_W;
  localparam int ACC_W     = PH_W + 7;
  localparam int PROD_W    = DEF_TDC_W + DEF_FR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // TDC fraction must never carry into the integer phase bits.
  function automatic logic [DEF_FR_W-1:0] sat_frac(
    input logic [PROD_W-1:0] prod
  );
    if (|prod[PROD_W-1:DEF_FR_W]) return '1;
    return prod[DEF_FR_W-1:0];
  endfunction

endpackage

// File: rtl/freqmeas_lockdet.sv
// Frequency-lock detector: counts consecutive in-window results.
module freqmeas_lockdet
  import freqmeas_pkg::*;
#(
  parameter int W = PH_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         stb,
  input  logic [W-1:0] ferr,
  input  logic [7:0]   tol,
  input  logic [3:0]   lcnt,
  output logic         locked
);

  logic [W-1:0] mag;
  logic         in_win;
  logic [4:0]   cnt;
  logic [4:0]   cnt_inc;
  logic         lock_set;

  assign mag      = ferr[W-1] ? -ferr : ferr;
  assign in_win   = (mag <= W'(tol));
  assign cnt_inc  = (cnt == 5'h1F) ? cnt : cnt + 5'd1;
  assign lock_set = (cnt_inc >= ({1'b0, lcnt} + 5'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      locked <= 1'b0;
    end else if (stb) begin
      if (in_win) begin
        cnt    <= cnt_inc;
        locked <= lock_set;
      end else begin
        cnt    <= '0;
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/vpac_tdc_freqmeas.sv
// REF-rate CKV frequency meter: fractional phase, differentiate,
// average over 2^AVG_SEL cycles and flag lock against FCW.
module vpac_tdc_freqmeas
  import freqmeas_pkg::*;
#(
  parameter int CNT_W = 7,
  parameter int TDC_W = 6,
  parameter int FR_W  = 16
) (
  input  logic                   REF,
  input  logic                   ARST,
  input  logic                   EN,
  input  logic [CNT_W-1:0]       CNT7BIT,
  input  logic [TDC_W-1:0]       TDCCODE,
  input  logic [15:0]            TDCRESNORM,
  input  logic [2:0]             AVG_SEL,
  input  logic [CNT_W+FR_W-1:0]  FCW,
  input  logic [7:0]             LOCK_TOL,
  input  logic [3:0]             LOCK_CNT,
  output logic [CNT_W+FR_W-1:0]  FMEAS,
  output logic                   FMEAS_VLD,
  output logic [CNT_W+FR_W:0]    FERR,
  output logic                   LOCKED,
  output logic                   BUSY
);

  state_t            state;
  logic [2:0]        avg_l;
  logic [6:0]        n;
  logic [ACC_W-1:0]  acc;
  logic [PH_W-1:0]   phase_prev;

  logic [PROD_W-1:0] prod;
  logic [FR_W-1:0]   frac;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   delta;
  logic [ACC_W-1:0]  acc_sum;
  logic [PH_W-1:0]   fmeas_new;
  logic [PH_W:0]     ferr_new;
  logic              n_last;
  logic              done;

  assign prod      = PROD_W'(TDCCODE) * PROD_W'(TDCRESNORM);
  assign frac      = sat_frac(prod);
  assign phase     = {CNT7BIT, {FR_W{1'b0}}} - {{CNT_W{1'b0}}, frac};
  // Modular difference hides the CKV counter wrap.
  assign delta     = phase - phase_prev;
  assign acc_sum   = acc + ACC_W'(delta);
  assign fmeas_new = PH_W'(acc_sum >> avg_l);
  assign ferr_new  = {1'b0, fmeas_new} - {1'b0, FCW};
  assign n_last    = (n == ((7'd1 << avg_l) - 7'd1));
  assign done      = EN && (state == ACCUM) && n_last;

  always_ff @(posedge REF or posedge ARST) begin
    if (ARST) begin
      state      <= IDLE;
      avg_l      <= '0;
      n          <= '0;
      acc        <= '0;
      phase_prev <= '0;
      FMEAS      <= '0;
      FERR       <= '0;
      FMEAS_VLD  <= 1'b0;
    end else begin
      FMEAS_VLD <= done;
      if (!EN) begin
        state      <= IDLE;
        n          <= '0;
        acc        <= '0;
        phase_prev <= '0;
      end else begin
        case (state)
          IDLE: begin
            state <= PRIME;
            avg_l <= AVG_SEL;
          end
          PRIME: begin
            phase_prev <= phase;
            state      <= ACCUM;
          end
          ACCUM: begin
            phase_prev <= phase;
            if (n_last) begin
              acc   <= '0;
              n     <= '0;
              FMEAS <= fmeas_new;
              FERR  <= ferr_new;
            end else begin
              acc <= acc_sum;
              n   <= n + 7'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign BUSY = (state != IDLE);

  freqmeas_lockdet #(.W(PH_W + 1)) u_lockdet (
    .clk    (REF),
    .rst    (ARST),
    .clr    (~EN),
    .stb    (done),
    .ferr   (ferr_new),
    .tol    (LOCK_TOL),
    .lcnt   (LOCK_CNT),
    .locked (LOCKED)
  );

endmodule
